dcache_ctrl: RTL and testbench

- Controller that sequences the direct-mapped write-through data cache: 16 lines × 16 words, 22-bit tag.
- Sits between the MEM stage of the RISC-V pipeline, the cache data array and the backing byte-addressed data memory.
- Owns tag/valid state, detects hit/miss, and runs a 16-beat line refill with a ready handshake (write-allocate).
- Serialises write-through stores (sw, sb) to memory and stalls the pipeline until each access completes.

---
 rtl/dcache_pkg.sv | 44 ++++
 rtl/dcache_tag_store.sv | 41 ++++
 rtl/dcache_ctrl.sv | 176 +++++++++++++++++
 tb/tb_dcache_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared geometry, state encoding and address helpers for the direct-mapped
// write-through data cache controller.
package dcache_pkg;

  localparam int LINES  = 16;
  localparam int WORDS  = 16;
  localparam int ADDR_W = 32;
  localparam int IDX_W  = 4;
  localparam int OFF_W  = 4;
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W - 2;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
    return addr[OFF_W+2 +: IDX_W];
  endfunction

  function automatic logic [OFF_W-1:0] addr_word(input logic [ADDR_W-1:0] addr);
    return addr[2 +: OFF_W];
  endfunction

  function automatic logic [3:0] sb_byte_en(input logic [1:0] byte_off);
    return 4'b0001 << byte_off;
  endfunction

  // The selected lane picks its byte out of the replicated word.
  function automatic logic [31:0] sb_wdata(input logic [31:0] wdata);
    return {4{wdata[7:0]}};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + CNT_W'(1);
  endfunction

endpackage

// File: rtl/dcache_tag_store.sv
// Tag and valid state for the direct-mapped cache: one lookup port with a
// combinational hit compare, plus fill (set valid) and invalidate ports.
module dcache_tag_store
  import dcache_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] lookup_index,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             hit,
  input  logic             fill_en,
  input  logic [IDX_W-1:0] fill_index,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic             inv_en,
  input  logic [IDX_W-1:0] inv_index
);

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [LINES];

  // NOTE: valid_d gets its default before any conditional update, so no latch is inferred.
  always_comb begin
    valid_d = valid_q;
    if (inv_en)  valid_d[inv_index]  = 1'b0;
    if (fill_en) valid_d[fill_index] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // NOTE: the tag array is deliberately not reset; a cleared valid bit masks stale tags.
  always_ff @(posedge clock) begin
    if (fill_en) tag_q[fill_index] <= fill_tag;
  end

  assign hit = valid_q[lookup_index] && (tag_q[lookup_index] == lookup_tag);

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through, write-allocate data cache controller: hit/miss
// detection, 16-beat line refill and serialised store write-through.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_sb,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  output logic [3:0]  arr_index,
  output logic [3:0]  arr_word,
  output logic        arr_we,
  output logic [3:0]  arr_byte_en,
  output logic [31:0] arr_wdata,
  input  logic [31:0] arr_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_byte_en,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  state_e           state_q, state_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hit_count_q, hit_count_d;
  logic [CNT_W-1:0] miss_count_q, miss_count_d;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_index;
  logic [OFF_W-1:0] req_word;
  logic             hit;
  logic             fill_en;
  logic             inv_en;
  logic [3:0]       store_be;
  logic [31:0]      store_data;
  logic [31:0]      store_addr;

  assign req_tag   = addr_tag(cpu_addr);
  assign req_index = addr_index(cpu_addr);
  assign req_word  = addr_word(cpu_addr);

  assign store_be   = cpu_sb ? sb_byte_en(cpu_addr[1:0]) : 4'hF;
  assign store_data = cpu_sb ? sb_wdata(cpu_wdata) : cpu_wdata;
  assign store_addr = cpu_sb ? cpu_addr : {cpu_addr[31:2], 2'b00};

  assign cpu_rdata  = arr_rdata;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

  dcache_tag_store u_tag_store (
    .clock        (clock),
    .reset        (reset),
    .lookup_index (req_index),
    .lookup_tag   (req_tag),
    .hit          (hit),
    .fill_en      (fill_en),
    .fill_index   (req_index),
    .fill_tag     (req_tag),
    .inv_en       (inv_en),
    .inv_index    (req_index)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    cpu_stall    = 1'b0;
    arr_index    = req_index;
    arr_word     = (state_q == REFILL) ? cnt_q : req_word;
    arr_we       = 1'b0;
    arr_byte_en  = 4'h0;
    arr_wdata    = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_byte_en  = 4'h0;
    mem_wdata    = '0;
    fill_en      = 1'b0;
    inv_en       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (hit) begin
            hit_count_d = sat_inc(hit_count_q);
            if (cpu_we) begin
              arr_we      = 1'b1;
              arr_byte_en = store_be;
              arr_wdata   = store_data;
              cpu_stall   = 1'b1;
              state_d     = WRITE;
            end
          end else begin
            // Invalidate up front so a partly refilled line can never hit.
            cpu_stall    = 1'b1;
            inv_en       = 1'b1;
            cnt_d        = '0;
            miss_count_d = sat_inc(miss_count_q);
            state_d      = REFILL;
          end
        end
      end

      REFILL: begin
        cpu_stall   = 1'b1;
        mem_req     = 1'b1;
        mem_addr    = {req_tag, req_index, cnt_q, 2'b00};
        mem_byte_en = 4'hF;
        if (mem_ready) begin
          arr_we      = 1'b1;
          arr_byte_en = 4'hF;
          arr_wdata   = mem_rdata;
          cnt_d       = cnt_q + OFF_W'(1);
          if (cnt_q == OFF_W'(WORDS - 1)) begin
            fill_en = 1'b1;
            state_d = IDLE;
          end
        end
      end

      WRITE: begin
        mem_req     = 1'b1;
        mem_we      = 1'b1;
        mem_addr    = store_addr;
        mem_byte_en = store_be;
        mem_wdata   = store_data;
        cpu_stall   = !mem_ready;
        if (mem_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Reset is asynchronous, so the buses must go quiet without waiting for an edge.
    if (reset) begin
      cpu_stall   = 1'b0;
      arr_index   = '0;
      arr_word    = '0;
      arr_we      = 1'b0;
      arr_byte_en = 4'h0;
      arr_wdata   = '0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_byte_en = 4'h0;
      mem_wdata   = '0;
      fill_en     = 1'b0;
      inv_en      = 1'b0;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus random traffic
// compared against an access-level model of a write-through cache.
module tb_dcache_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_sb;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic [3:0]  arr_index, arr_word;
  logic        arr_we;
  logic [3:0]  arr_byte_en;
  logic [31:0] arr_wdata, arr_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ready;
  logic [15:0] hit_count, miss_count;

  dcache_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_sb      (cpu_sb),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_stall   (cpu_stall),
    .cpu_rdata   (cpu_rdata),
    .arr_index   (arr_index),
    .arr_word    (arr_word),
    .arr_we      (arr_we),
    .arr_byte_en (arr_byte_en),
    .arr_wdata   (arr_wdata),
    .arr_rdata   (arr_rdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_byte_en (mem_byte_en),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Environment: data array, backing memory (4 KiB window) and a ready generator.
  logic [31:0] data_arr [256];
  logic [31:0] env_mem  [1024];
  int          mem_lat   = 1;
  int          wait_cnt  = 0;
  logic [31:0] rd_log [$];
  int          wr_n      = 0;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_be;
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;
  int          addr_moves = 0;

  assign arr_rdata = data_arr[{arr_index, arr_word}];
  assign mem_rdata = env_mem[mem_addr[11:2]];
  assign mem_ready = (wait_cnt >= mem_lat - 1);

  always @(posedge clock) begin
    if (arr_we)
      for (int b = 0; b < 4; b++)
        if (arr_byte_en[b]) data_arr[{arr_index, arr_word}][8*b +: 8] <= arr_wdata[8*b +: 8];
    if (mem_req && mem_ready) begin
      wait_cnt <= 0;
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_byte_en[b]) env_mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        wr_n    <= wr_n + 1;
        wr_addr <= mem_addr;
        wr_be   <= mem_byte_en;
        wr_data <= mem_wdata;
      end else begin
        rd_log.push_back(mem_addr);
      end
    end else if (mem_req) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
    if (prev_wait && mem_req && mem_addr != prev_addr) addr_moves <= addr_moves + 1;
    prev_wait <= mem_req && !mem_ready;
    prev_addr <= mem_addr;
  end

  // Reference model: which tag each line holds, the memory image, and counters.
  logic        ref_valid [16];
  logic [21:0] ref_tag   [16];
  logic [31:0] ref_mem   [1024];
  int          ref_hits, ref_misses;

  function automatic logic [31:0] init_word(input int w);
    return (32'(w) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
    ref_hits   = 0;
    ref_misses = 0;
  endtask

  task automatic do_access(input logic we, input logic sb, input logic [31:0] addr,
                           input logic [31:0] wdata, input int lat,
                           output int stalls, output logic [31:0] rdata,
                           output logic first_we, output logic [3:0] first_be,
                           output logic [31:0] first_wd, output logic timeout);
    @(negedge clock);
    mem_lat   = lat;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_sb    = sb;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    stalls    = 0;
    timeout   = 1'b0;
    #1;
    first_we = arr_we;
    first_be = arr_byte_en;
    first_wd = arr_wdata;
    while (cpu_stall) begin
      stalls++;
      if (stalls > 300) begin
        timeout = 1'b1;
        break;
      end
      @(negedge clock);
      #1;
    end
    rdata = cpu_rdata;
    @(negedge clock);
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    cpu_sb  = 1'b0;
  endtask

  task automatic run_and_check(input string name, input logic we, input logic sb,
                               input logic [31:0] addr, input logic [31:0] wdata, input int lat);
    int          stalls, rd_base, wr_base, beats, bad, exp_stalls;
    logic [31:0] rdata, first_wd, line_base;
    logic [3:0]  first_be, idx;
    logic        first_we, timeout, is_hit;
    logic [31:0] exp_addr, exp_data;
    logic [3:0]  exp_be;

    idx       = addr[9:6];
    is_hit    = ref_valid[idx] && ref_tag[idx] == addr[31:10];
    line_base = {addr[31:6], 6'b0};
    exp_stalls = (is_hit ? 0 : 1 + 16 * lat) + (we ? lat : 0);
    exp_be     = sb ? (4'b0001 << addr[1:0]) : 4'hF;
    exp_data   = sb ? {4{wdata[7:0]}} : wdata;
    exp_addr   = sb ? addr : {addr[31:2], 2'b00};

    rd_base = rd_log.size();
    wr_base = wr_n;
    do_access(we, sb, addr, wdata, lat, stalls, rdata, first_we, first_be, first_wd, timeout);

    if (!is_hit) begin
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = addr[31:10];
      if (ref_misses < 65535) ref_misses++;
    end
    if (ref_hits < 65535) ref_hits++;
    if (we)
      for (int b = 0; b < 4; b++)
        if (exp_be[b]) ref_mem[addr[11:2]][8*b +: 8] = exp_data[8*b +: 8];

    check({name, ".timeout"}, 32'(timeout), 0);
    check({name, ".stalls"}, stalls, exp_stalls);
    check({name, ".hit_count"}, 32'(hit_count), ref_hits);
    check({name, ".miss_count"}, 32'(miss_count), ref_misses);
    check({name, ".first_arr_we"}, 32'(first_we), 32'(we && is_hit));
    if (!we) check({name, ".rdata"}, rdata, ref_mem[addr[11:2]]);
    if (we && is_hit) begin
      check({name, ".arr_byte_en"}, 32'(first_be), 32'(exp_be));
      check({name, ".arr_wdata"}, first_wd, exp_data);
    end

    beats = rd_log.size() - rd_base;
    check({name, ".refill_beats"}, beats, is_hit ? 0 : 16);
    bad = 0;
    for (int i = 0; i < beats && i < 16; i++)
      if (rd_log[rd_base + i] != line_base + 32'(4 * i)) bad++;
    check({name, ".refill_addrs_bad"}, bad, 0);

    check({name, ".mem_writes"}, wr_n - wr_base, we ? 1 : 0);
    if (we) begin
      check({name, ".mem_wr_addr"}, wr_addr, exp_addr);
      check({name, ".mem_wr_be"}, 32'(wr_be), 32'(exp_be));
      check({name, ".mem_wr_data"}, wr_data, exp_data);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          guard;
    logic [31:0] a, d;
    logic        w, s;

    for (int i = 0; i < 1024; i++) begin
      env_mem[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    env_mem[1] = 32'h0DCC0BAA;
    ref_mem[1] = 32'h0DCC0BAA;
    for (int i = 0; i < 256; i++) data_arr[i] = 32'h0;

    reset     = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_sb    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    model_reset();
    repeat (3) @(negedge clock);
    check("rst.cpu_stall", 32'(cpu_stall), 0);
    check("rst.mem_req", 32'(mem_req), 0);
    check("rst.hit_count", 32'(hit_count), 0);
    check("rst.miss_count", 32'(miss_count), 0);
    reset = 1'b0;

    run_and_check("rd_miss_04", 1'b0, 1'b0, 32'h04, 32'h0, 1);
    run_and_check("rd_hit_04", 1'b0, 1'b0, 32'h04, 32'h0, 1);
    run_and_check("sb_05", 1'b1, 1'b1, 32'h05, 32'h000000EE, 1);
    run_and_check("rd_after_sb", 1'b0, 1'b0, 32'h04, 32'h0, 1);
    check("rd_after_sb.value", ref_mem[1], 32'h0DCCEEAA);
    run_and_check("sw_08", 1'b1, 1'b0, 32'h0B, 32'hCAFE1234, 1);
    run_and_check("rd_400", 1'b0, 1'b0, 32'h400, 32'h0, 1);
    run_and_check("rd_04_evicted", 1'b0, 1'b0, 32'h04, 32'h0, 1);
    run_and_check("sw_miss_c80", 1'b1, 1'b0, 32'hC80, 32'h13572468, 1);

    addr_moves = 0;
    run_and_check("rd_miss_slow", 1'b0, 1'b0, 32'h840, 32'h0, 3);
    check("slow.addr_stable", addr_moves, 0);
    run_and_check("sb_hit_slow", 1'b1, 1'b1, 32'h847, 32'h000000A5, 3);

    // Reset during beat 8 of a refill into line 0.
    @(negedge clock);
    mem_lat  = 1;
    guard    = rd_log.size();
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_sb   = 1'b0;
    cpu_addr = 32'h800;
    for (int n = 0; n < 100 && rd_log.size() - guard < 8; n++) @(negedge clock);
    check("mid_rst.beats_before", rd_log.size() - guard, 8);
    reset = 1'b1;
    #1;
    check("mid_rst.cpu_stall", 32'(cpu_stall), 0);
    check("mid_rst.mem_req", 32'(mem_req), 0);
    check("mid_rst.arr_we", 32'(arr_we), 0);
    check("mid_rst.hit_count", 32'(hit_count), 0);
    check("mid_rst.miss_count", 32'(miss_count), 0);
    cpu_req = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    run_and_check("rd_04_post_rst", 1'b0, 1'b0, 32'h04, 32'h0, 1);

    addr_moves = 0;
    for (int i = 0; i < 120; i++) begin
      a = {20'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 6'($urandom_range(0, 63))};
      d = $urandom;
      w = ($urandom_range(0, 2) == 0);
      s = w && ($urandom_range(0, 1) == 1);
      run_and_check($sformatf("rand%0d", i), w, s, a, d, $urandom_range(1, 3));
    end
    check("rand.addr_stable", addr_moves, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
